// File: rtl/pueo_trig_merge.sv
`default_nettype none
// ============================================================================
//  Module      : pueo_trig_merge
//  Description : Merges the software, PPS and external trigger streams into
//                one valid/ready trigger stream for the event builder.
//                Each source owns a one-deep pending slot that is filled on
//                the rising edge of its (multi-cycle) valid. A fixed-priority
//                arbiter (pps > ext > soft) feeds an IDLE/OUTPUT/HOLDOFF FSM.
//                Accepted and dropped triggers are counted per run.
//  Ports       : sysclk_i / sysclk_rstn_i   clock, async active-low reset
//                running_i                  run enable, low clears run state
//                holdoff_i                  post-accept dead time (cycles)
//                {soft,pps,ext}_*_i         per-source addr/metadata/valid
//                trig_o/metadata_o/source_o merged trigger, source 1/2/3
//                valid_o / ready_i          downstream handshake
//                event_o                    pulse on each accepted trigger
//                trig_count_o/drop_count_o  accepted / dropped counters
//                drop_o                     pulse per dropped trigger
//  Revision    : 1.0 - initial release
// ============================================================================
module pueo_trig_merge #(
    parameter     SYSCLKTYPE    = "NONE",
    parameter int HOLDOFF_WIDTH = 16
) (
    input  wire logic                     sysclk_i,
    input  wire logic                     sysclk_rstn_i,
    input  wire logic                     running_i,
    input  wire logic [HOLDOFF_WIDTH-1:0] holdoff_i,
    input  wire logic [11:0]              soft_trig_i,
    input  wire logic [7:0]               soft_metadata_i,
    input  wire logic                     soft_valid_i,
    input  wire logic [11:0]              pps_trig_i,
    input  wire logic [7:0]               pps_metadata_i,
    input  wire logic                     pps_valid_i,
    input  wire logic [11:0]              ext_trig_i,
    input  wire logic [7:0]               ext_metadata_i,
    input  wire logic                     ext_valid_i,
    output logic [11:0]                   trig_o,
    output logic [7:0]                    metadata_o,
    output logic [1:0]                    source_o,
    output logic                          valid_o,
    input  wire logic                     ready_i,
    output logic                          event_o,
    output logic [31:0]                   trig_count_o,
    output logic [15:0]                   drop_count_o,
    output logic                          drop_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OUTPUT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int         c_nsrc     = 3;
    localparam logic [1:0] c_src_soft = 2'd1;
    localparam logic [1:0] c_src_pps  = 2'd2;
    localparam logic [1:0] c_src_ext  = 2'd3;

    // Reset: asynchronous assertion, release synchronised to sysclk_i.
    (* CUSTOM_CC_DST = SYSCLKTYPE *) logic [1:0] r_rst_sync;
    logic w_rstn;

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) r_rst_sync <= 2'b00;
        else                r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rstn = r_rst_sync[1];

    // Source vectors, index 0 = soft, 1 = pps, 2 = ext.
    logic [c_nsrc-1:0] w_in_valid;
    logic [11:0]       w_in_trig   [c_nsrc];
    logic [7:0]        w_in_meta   [c_nsrc];
    logic [c_nsrc-1:0] w_pend;
    logic [c_nsrc-1:0] w_take;
    logic [c_nsrc-1:0] w_drop;
    logic [11:0]       w_slot_trig [c_nsrc];
    logic [7:0]        w_slot_meta [c_nsrc];

    assign w_in_valid   = {ext_valid_i, pps_valid_i, soft_valid_i};
    assign w_in_trig[0] = soft_trig_i;
    assign w_in_trig[1] = pps_trig_i;
    assign w_in_trig[2] = ext_trig_i;
    assign w_in_meta[0] = soft_metadata_i;
    assign w_in_meta[1] = pps_metadata_i;
    assign w_in_meta[2] = ext_metadata_i;

    for (genvar g = 0; g < c_nsrc; g++) begin : g_slot
        (* CUSTOM_CC_DST = SYSCLKTYPE *) logic r_valid_q;
        logic        r_pend;
        logic [11:0] r_trig;
        logic [7:0]  r_meta;
        logic        w_cap;

        // Only the first cycle of the held valid is a capture.
        assign w_cap     = running_i & w_in_valid[g] & ~r_valid_q;
        // A slot being drained this cycle has room for the new capture.
        assign w_drop[g] = w_cap & r_pend & ~w_take[g];

        always_ff @(posedge sysclk_i or negedge w_rstn) begin
            if (!w_rstn) begin
                r_valid_q <= 1'b0;
                r_pend    <= 1'b0;
                r_trig    <= '0;
                r_meta    <= '0;
            end else begin
                r_valid_q <= w_in_valid[g];
                if (!running_i) begin
                    r_pend <= 1'b0;
                end else if (w_cap && (!r_pend || w_take[g])) begin
                    r_pend <= 1'b1;
                    r_trig <= w_in_trig[g];
                    r_meta <= w_in_meta[g];
                end else if (w_take[g]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign w_pend[g]      = r_pend;
        assign w_slot_trig[g] = r_trig;
        assign w_slot_meta[g] = r_meta;
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_valid;
    logic [11:0]            r_trig_out;
    logic [7:0]             r_meta_out;
    logic [1:0]             r_src_out;
    logic [31:0]            r_trig_count;
    logic [15:0]            r_drop_count;
    logic                   r_drop;
    logic [HOLDOFF_WIDTH-1:0] r_hold_cnt;

    logic [1:0]             w_sel_src;
    logic [11:0]            w_sel_trig;
    logic [7:0]             w_sel_meta;
    logic                   w_load;
    logic                   w_accept;
    logic [HOLDOFF_WIDTH:0] w_hold_next;
    logic                   w_hold_done;
    logic [1:0]             w_drop_n;
    logic [16:0]            w_drop_sum;

    // Fixed-priority arbiter, only active in IDLE.
    always_comb begin
        w_take     = '0;
        w_sel_src  = 2'd0;
        w_sel_trig = '0;
        w_sel_meta = '0;
        if (running_i && r_state == ST_IDLE) begin
            if (w_pend[1]) begin
                w_take[1]  = 1'b1;
                w_sel_src  = c_src_pps;
                w_sel_trig = w_slot_trig[1];
                w_sel_meta = w_slot_meta[1];
            end else if (w_pend[2]) begin
                w_take[2]  = 1'b1;
                w_sel_src  = c_src_ext;
                w_sel_trig = w_slot_trig[2];
                w_sel_meta = w_slot_meta[2];
            end else if (w_pend[0]) begin
                w_take[0]  = 1'b1;
                w_sel_src  = c_src_soft;
                w_sel_trig = w_slot_trig[0];
                w_sel_meta = w_slot_meta[0];
            end
        end
    end

    assign w_load = |w_take;

    // The accept cycle counts toward the dead time, so with a non-zero
    // holdoff valid_o can rise again holdoff_i+1 cycles after the accept.
    assign w_hold_next = {1'b0, r_hold_cnt} + {{HOLDOFF_WIDTH{1'b0}}, 1'b1};
    assign w_hold_done = (w_hold_next >= {1'b0, holdoff_i});

    always_ff @(posedge sysclk_i or negedge w_rstn) begin
        if (!w_rstn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (!running_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) w_state_next = ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (ready_i) begin
                        w_accept     = 1'b1;
                        w_state_next = (holdoff_i != '0) ? ST_HOLDOFF : ST_IDLE;
                    end
                end
                ST_HOLDOFF: begin
                    if (w_hold_done) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_drop_n   = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};
    assign w_drop_sum = {1'b0, r_drop_count} + {15'd0, w_drop_n};

    always_ff @(posedge sysclk_i or negedge w_rstn) begin
        if (!w_rstn) begin
            r_valid      <= 1'b0;
            r_trig_out   <= '0;
            r_meta_out   <= '0;
            r_src_out    <= '0;
            r_trig_count <= '0;
            r_drop_count <= '0;
            r_drop       <= 1'b0;
            r_hold_cnt   <= '0;
        end else if (!running_i) begin
            r_valid      <= 1'b0;
            r_trig_count <= '0;
            r_drop_count <= '0;
            r_drop       <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_trig_out <= w_sel_trig;
                r_meta_out <= w_sel_meta;
                r_src_out  <= w_sel_src;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_accept) r_trig_count <= r_trig_count + 32'd1;
            r_drop <= |w_drop;
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_accept)                    r_hold_cnt <= {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
            else if (r_state == ST_HOLDOFF)  r_hold_cnt <= w_hold_next[HOLDOFF_WIDTH-1:0];
        end
    end

    assign trig_o       = r_trig_out;
    assign metadata_o   = r_meta_out;
    assign source_o     = r_src_out;
    assign valid_o      = r_valid;
    assign event_o      = w_accept;
    assign trig_count_o = r_trig_count;
    assign drop_count_o = r_drop_count;
    assign drop_o       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pueo_trig_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pueo_trig_merge
//  Description : Directed self-checking bench for pueo_trig_merge. Inputs
//                change 1 time unit after the rising edge; outputs are
//                sampled at that same point, so "cycle k" below means the
//                interval after the k-th edge of the scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pueo_trig_merge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        running;
    logic [15:0] holdoff;
    logic [11:0] soft_trig, pps_trig, ext_trig;
    logic [7:0]  soft_meta, pps_meta, ext_meta;
    logic        soft_valid, pps_valid, ext_valid;
    logic        ready;
    logic [11:0] trig;
    logic [7:0]  meta;
    logic [1:0]  source;
    logic        valid;
    logic        evt;
    logic [31:0] trig_count;
    logic [15:0] drop_count;
    logic        drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pueo_trig_merge #(
        .SYSCLKTYPE    ("NONE"),
        .HOLDOFF_WIDTH (16)
    ) dut (
        .sysclk_i        (clk),
        .sysclk_rstn_i   (rstn),
        .running_i       (running),
        .holdoff_i       (holdoff),
        .soft_trig_i     (soft_trig),
        .soft_metadata_i (soft_meta),
        .soft_valid_i    (soft_valid),
        .pps_trig_i      (pps_trig),
        .pps_metadata_i  (pps_meta),
        .pps_valid_i     (pps_valid),
        .ext_trig_i      (ext_trig),
        .ext_metadata_i  (ext_meta),
        .ext_valid_i     (ext_valid),
        .trig_o          (trig),
        .metadata_o      (meta),
        .source_o        (source),
        .valid_o         (valid),
        .ready_i         (ready),
        .event_o         (evt),
        .trig_count_o    (trig_count),
        .drop_count_o    (drop_count),
        .drop_o          (drop)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trig"},   {20'd0, trig},       32'd0);
        chk({tag, "_meta"},   {24'd0, meta},       32'd0);
        chk({tag, "_src"},    {30'd0, source},     32'd0);
        chk({tag, "_valid"},  {31'd0, valid},      32'd0);
        chk({tag, "_event"},  {31'd0, evt},        32'd0);
        chk({tag, "_tcount"}, trig_count,          32'd0);
        chk({tag, "_dcount"}, {16'd0, drop_count}, 32'd0);
        chk({tag, "_drop"},   {31'd0, drop},       32'd0);
    endtask

    initial begin
        rstn = 1'b0; running = 1'b1; holdoff = 16'd0; ready = 1'b1;
        soft_trig = '0; pps_trig = '0; ext_trig = '0;
        soft_meta = '0; pps_meta = '0; ext_meta = '0;
        soft_valid = 1'b0; pps_valid = 1'b0; ext_valid = 1'b0;

        // ---- reset state ----
        tick(3);
        chk_all_zero("reset");
        rstn = 1'b1;
        tick(4);
        chk("post_reset_valid", {31'd0, valid}, 32'd0);

        // ---- single soft trigger ----
        soft_trig = 12'h123; soft_meta = 8'h80; soft_valid = 1'b1;     // cycle N
        tick(1);                                                        // N+1
        chk("soft_n1_valid", {31'd0, valid}, 32'd0);
        tick(1);                                                        // N+2
        chk("soft_valid",  {31'd0, valid},  32'd1);
        chk("soft_trig",   {20'd0, trig},   32'h123);
        chk("soft_meta",   {24'd0, meta},   32'h80);
        chk("soft_src",    {30'd0, source}, 32'd1);
        chk("soft_event",  {31'd0, evt},    32'd1);
        tick(1);                                                        // N+3
        chk("soft_n3_valid", {31'd0, valid}, 32'd0);
        chk("soft_count",    trig_count,     32'd1);
        tick(1);                                                        // N+4
        soft_valid = 1'b0;
        chk("soft_no_repeat", {31'd0, valid}, 32'd0);
        tick(2);

        // ---- simultaneous edges on all three sources ----
        pps_trig  = 12'h010; pps_meta  = 8'h01; pps_valid  = 1'b1;
        ext_trig  = 12'h020; ext_meta  = 8'h02; ext_valid  = 1'b1;
        soft_trig = 12'h030; soft_meta = 8'h03; soft_valid = 1'b1;     // cycle M
        tick(2);                                                        // M+2
        chk("sim_first_trig", {20'd0, trig},   32'h010);
        chk("sim_first_src",  {30'd0, source}, 32'd2);
        chk("sim_first_valid",{31'd0, valid},  32'd1);
        tick(1);                                                        // M+3
        chk("sim_gap1_valid", {31'd0, valid}, 32'd0);
        tick(1);                                                        // M+4
        pps_valid = 1'b0; ext_valid = 1'b0; soft_valid = 1'b0;
        chk("sim_second_trig", {20'd0, trig},   32'h020);
        chk("sim_second_src",  {30'd0, source}, 32'd3);
        chk("sim_second_meta", {24'd0, meta},   32'h02);
        tick(1);                                                        // M+5
        chk("sim_gap2_valid", {31'd0, valid}, 32'd0);
        tick(1);                                                        // M+6
        chk("sim_third_trig",  {20'd0, trig},   32'h030);
        chk("sim_third_src",   {30'd0, source}, 32'd1);
        chk("sim_third_valid", {31'd0, valid},  32'd1);
        tick(1);                                                        // M+7
        chk("sim_count",  trig_count,          32'd4);
        chk("sim_drops",  {16'd0, drop_count}, 32'd0);
        tick(2);

        // ---- stall, second capture, third capture dropped ----
        ready = 1'b0;
        pps_trig = 12'h111; pps_meta = 8'h11; pps_valid = 1'b1;        // cycle P
        tick(2);                                                        // P+2
        chk("stall_valid", {31'd0, valid}, 32'd1);
        chk("stall_trig",  {20'd0, trig},  32'h111);
        chk("stall_event", {31'd0, evt},   32'd0);
        tick(2);                                                        // P+4
        pps_valid = 1'b0;
        tick(2);                                                        // P+6
        pps_trig = 12'h222; pps_meta = 8'h22; pps_valid = 1'b1;
        tick(4);                                                        // P+10
        pps_valid = 1'b0;
        tick(4);                                                        // P+14
        pps_trig = 12'h333; pps_meta = 8'h33; pps_valid = 1'b1;
        chk("stall_pre_drop", {31'd0, drop}, 32'd0);
        tick(1);                                                        // P+15
        chk("stall_drop_pulse", {31'd0, drop},       32'd1);
        chk("stall_drop_count", {16'd0, drop_count}, 32'd1);
        tick(1);                                                        // P+16
        chk("stall_drop_once",  {31'd0, drop}, 32'd0);
        tick(2);                                                        // P+18
        pps_valid = 1'b0;
        tick(2);                                                        // P+20
        chk("stall_hold_trig",  {20'd0, trig}, 32'h111);
        chk("stall_hold_meta",  {24'd0, meta}, 32'h11);
        chk("stall_hold_valid", {31'd0, valid}, 32'd1);
        tick(2);                                                        // P+22
        ready = 1'b1;
        #1;
        chk("stall_accept_event", {31'd0, evt}, 32'd1);
        tick(1);                                                        // P+23
        chk("stall_acc_valid", {31'd0, valid}, 32'd0);
        chk("stall_acc_count", trig_count,     32'd5);
        tick(1);                                                        // P+24
        chk("stall_second_trig",  {20'd0, trig},   32'h222);
        chk("stall_second_valid", {31'd0, valid},  32'd1);
        tick(1);                                                        // P+25
        tick(3);
        chk("stall_no_third",  {31'd0, valid},      32'd0);
        chk("stall_count_end", trig_count,          32'd6);
        chk("stall_drop_end",  {16'd0, drop_count}, 32'd1);

        // ---- holdoff 100 ----
        holdoff = 16'd100;
        ext_trig = 12'h0AA; ext_meta = 8'hA0; ext_valid = 1'b1;        // cycle H
        tick(2);                                                        // H+2 (accept)
        chk("hold_first_valid", {31'd0, valid}, 32'd1);
        chk("hold_first_event", {31'd0, evt},   32'd1);
        tick(2);                                                        // H+4
        ext_valid = 1'b0;
        tick(6);                                                        // H+10
        ext_trig = 12'h0BB; ext_meta = 8'hB0; ext_valid = 1'b1;
        tick(4);                                                        // H+14
        ext_valid = 1'b0;
        tick(88);                                                       // H+102
        chk("hold_early_valid", {31'd0, valid}, 32'd0);
        tick(1);                                                        // H+103
        chk("hold_second_valid", {31'd0, valid},  32'd1);
        chk("hold_second_trig",  {20'd0, trig},   32'h0BB);
        chk("hold_second_src",   {30'd0, source}, 32'd3);
        tick(110);
        holdoff = 16'd0;
        tick(2);

        // ---- running_i falls during OUTPUT with soft pending ----
        ready = 1'b0;
        pps_trig  = 12'h0C1; pps_meta  = 8'hC1; pps_valid  = 1'b1;
        soft_trig = 12'h0C2; soft_meta = 8'hC2; soft_valid = 1'b1;     // cycle R
        tick(2);                                                        // R+2
        chk("run_out_trig", {20'd0, trig}, 32'h0C1);
        running = 1'b0; ready = 1'b1;
        #1;
        chk("run_no_event", {31'd0, evt}, 32'd0);
        tick(1);                                                        // R+3
        chk("run_valid_clr",  {31'd0, valid},      32'd0);
        chk("run_count_clr",  trig_count,          32'd0);
        chk("run_drops_clr",  {16'd0, drop_count}, 32'd0);
        running = 1'b1;
        tick(1);                                                        // R+4
        pps_valid = 1'b0; soft_valid = 1'b0;
        tick(2);                                                        // R+6
        chk("run_slot_cleared", {31'd0, valid}, 32'd0);
        chk("run_count_still0", trig_count,     32'd0);
        pps_trig = 12'h0D0; pps_meta = 8'hD0; pps_valid = 1'b1;        // cycle S
        tick(2);                                                        // S+2
        chk("run_new_valid", {31'd0, valid}, 32'd1);
        chk("run_new_trig",  {20'd0, trig},  32'h0D0);
        tick(1);                                                        // S+3
        chk("run_new_count", trig_count, 32'd1);
        tick(1);
        pps_valid = 1'b0;
        tick(2);

        // ---- async reset in HOLDOFF ----
        holdoff = 16'd50;
        ext_trig = 12'h0E1; ext_meta = 8'hE1; ext_valid = 1'b1;        // cycle T
        tick(2);                                                        // T+2 (accept)
        chk("ar_accept_event", {31'd0, evt}, 32'd1);
        tick(1);                                                        // T+3
        chk("ar_count_before", trig_count, 32'd2);
        tick(1);
        ext_valid = 1'b0;
        tick(6);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("areset");
        holdoff = 16'd0;
        tick(2);
        rstn = 1'b1;
        tick(3);
        pps_trig = 12'h0E0; pps_meta = 8'hE0; pps_valid = 1'b1;        // cycle U
        tick(1);                                                        // U+1
        chk("ar_n1_valid", {31'd0, valid}, 32'd0);
        tick(1);                                                        // U+2
        chk("ar_valid", {31'd0, valid},  32'd1);
        chk("ar_trig",  {20'd0, trig},   32'h0E0);
        chk("ar_src",   {30'd0, source}, 32'd2);
        tick(2);
        pps_valid = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
